// File: rtl/gigatron_input.sv
// gigatron_input: serial game-controller port feeding the Gigatron core's input bus.
// Optional host injector is compiled in with GIGATRON_INPUT_INJECT_EN.
module gigatron_input #(
    parameter int INJ_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] out,
    input  logic       ie_n,
    inout  wire  [7:0] bus,
    input  logic       ctrl_data,
    output logic       ctrl_latch,
    output logic       ctrl_clock,
    output logic [7:0] inreg,
    output logic [7:0] line_count
`ifdef GIGATRON_INPUT_INJECT_EN
    ,
    input  logic       inj_valid,
    output logic       inj_ready,
    input  logic [7:0] inj_data
`endif
);
    logic [1:0] sync_q;
    logic       hs_q, vs_q, sdata, hs_rise, vs_rise, out_unused;
    logic [7:0] sr_q, sr_d, inreg_q, inreg_d, lc_q, lc_d, inreg_eff;

    assign sdata      = sync_q[1];
    assign hs_rise    = out[6] & ~hs_q;
    assign vs_rise    = out[7] & ~vs_q;
    assign ctrl_clock = hs_q;
    assign ctrl_latch = vs_q;
    assign line_count = lc_q;
    assign inreg      = inreg_eff;
    assign bus        = ie_n ? 8'hZZ : inreg_eff;
    assign out_unused = ^out[5:0];

    // Shift on hsync, latch the pre-shift byte on vsync, count lines between vsyncs
    always_comb begin
        sr_d    = hs_rise ? {sr_q[6:0], sdata} : sr_q;
        inreg_d = vs_rise ? sr_q : inreg_q;
        lc_d    = vs_rise ? 8'd0 : (hs_rise && lc_q != 8'hFF) ? lc_q + 8'd1 : lc_q;
    end

    // Synchronizer, sync edge detectors and frame state; reset parks everything high/idle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            sr_q    <= 8'hFF;
            inreg_q <= 8'hFF;
            lc_q    <= 8'd0;
        end else begin
            sync_q  <= {sync_q[0], ctrl_data};
            hs_q    <= out[6];
            vs_q    <= out[7];
            sr_q    <= sr_d;
            inreg_q <= inreg_d;
            lc_q    <= lc_d;
        end
    end

`ifdef GIGATRON_INPUT_INJECT_EN
    localparam logic IDLE = 1'b0;
    localparam logic HOLD = 1'b1;

    logic       st_q, st_d, accept;
    logic [7:0] fc_q, fc_d, ihold_q, ihold_d;

    assign accept    = (st_q == IDLE) & inj_valid;
    assign inj_ready = (st_q == IDLE);
    assign inreg_eff = (st_q == HOLD) ? ihold_q : inreg_q;

    // Injector: capture a byte and hold it over the bus for INJ_FRAMES vsync edges
    always_comb begin
        st_d    = accept ? HOLD : (st_q == HOLD && vs_rise && fc_q == 8'd1) ? IDLE : st_q;
        fc_d    = accept ? 8'(INJ_FRAMES) : (st_q == HOLD && vs_rise) ? fc_q - 8'd1 : fc_q;
        ihold_d = accept ? inj_data : ihold_q;
    end

    // Injector state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q    <= IDLE;
            fc_q    <= 8'd0;
            ihold_q <= 8'hFF;
        end else begin
            st_q    <= st_d;
            fc_q    <= fc_d;
            ihold_q <= ihold_d;
        end
    end
`else
    assign inreg_eff = inreg_q;
`endif
endmodule

// File: doc/gigatron_input.md
# gigatron_input

Serial game-controller input port for the Gigatron core. Sits directly upstream of the core's input bus path. It regenerates the controller latch/clock from the core's OUT register: hsync is OUT bit 6 and vsync is OUT bit 7. It shifts in controller serial data on each hsync rising edge and latches a stable byte on each vsync rising edge. It drives that byte onto the shared data bus whenever the core asserts `ie_n`.

## Interface
Parameters:
- `INJ_FRAMES`, default 2: number of vsync rising edges an injected byte overrides the controller (1..255).

Ports:
- `clk`  input  1: core clock, same clock as the CPU.
- `reset_n`  input  1: synchronous, active-low reset.
- `out`  input  8: core OUT register. Bit 6 is hsync and bit 7 is vsync.
- `ie_n`  input  1: core input-enable, active-low, combinational from the core's IR.
- `bus`  inout  8: shared data bus. Driven only while `ie_n`=0, high-Z otherwise.
- `ctrl_data`  input  1: controller serial data, asynchronous, active-low buttons.
- `ctrl_latch`  output  1: controller latch/strobe.
- `ctrl_clock`  output  1: controller shift clock.
- `inreg`  output  8: current latched input byte, for debug and visibility.
- `line_count`  output  8: hsync rising edges since the last vsync rising edge, saturating.
- `inj_valid`  input  1: host inject request. Present only with `GIGATRON_INPUT_INJECT_EN`.
- `inj_ready`  output  1: injector idle, request accepted. Present only with `GIGATRON_INPUT_INJECT_EN`.
- `inj_data`  input  8: byte to inject. Present only with `GIGATRON_INPUT_INJECT_EN`.

## Operation
- `ctrl_data` passes through a 2-flop synchronizer. `sdata` is the second-stage output.
- `hs_q`/`vs_q` are registered copies of `out[6]`/`out[7]`.
  - `hs_rise` = `out[6] & !hs_q`.
  - `vs_rise` = `out[7] & !vs_q`.
- `ctrl_clock` = `hs_q` and `ctrl_latch` = `vs_q`. Both are registered, with no combinational path from `out`.
- Shift register `sr[7:0]`: on `hs_rise`, `sr <= {sr[6:0], sdata}`.
- Latch: on `vs_rise`, `inreg <= sr`, unless an injection is holding (see below).
- Simultaneous `hs_rise` and `vs_rise`:
  - `inreg` takes the pre-shift `sr`.
  - `sr` still shifts.
  - `line_count` resets to 0.
- `line_count`:
  - On `vs_rise`, cleared to 0.
  - Otherwise incremented on `hs_rise`, saturating at 255.
- Bus drive: `bus = ie_n ? 8'hZZ : inreg_eff`. This path is combinational, so the value is valid in the same cycle the core reads it.
  - `inreg_eff` = `inreg` when not injecting.
  - `inreg_eff` = the held injected byte when injecting.
  - The `inreg` output always shows `inreg_eff`.
- No polarity inversion. Released buttons read as 1, so an unplugged input with a pulled-up `ctrl_data` reads 8'hFF.

## Timing
Reset values (`reset_n`=0 at a clk edge):
- `sr`=8'hFF, `inreg`=8'hFF, `line_count`=0.
- `hs_q`=1, `vs_q`=1, so no spurious edge is seen after reset.
- Synchronizer flops = 1.
- `ctrl_clock`=1, `ctrl_latch`=1.
- `inj_ready`=1, injector in IDLE.

Latencies:
- `ctrl_data` reaches `sdata` after 2 clk edges.
- `sdata` is sampled at the clk edge where `hs_rise` is true.
- `out` edge to `ctrl_clock`/`ctrl_latch`: 1 cycle.
- `vs_rise` to new `inreg`: visible the cycle after the edge.

Reset mid-frame discards `sr` contents, clears the latch and aborts any injection. The bus is released during reset unless `ie_n`=0.

## Configuration
Macro: `GIGATRON_INPUT_INJECT_EN`.

With the macro defined, the host injector is compiled in:
- States: IDLE and HOLD, with an 8-bit frame counter `fc`.
- IDLE:
  - `inj_ready`=1.
  - When `inj_valid` and `inj_ready` are both high at a clk edge, capture `inj_data` into `ihold`, set `fc=INJ_FRAMES` and go to HOLD.
- HOLD:
  - `inj_ready`=0, `inreg_eff`=`ihold`.
  - Each `vs_rise` decrements `fc`. The real `inreg` still latches `sr` as normal.
  - When `fc` reaches 0 on a `vs_rise`, return to IDLE. `inreg_eff` reverts to `inreg` the following cycle.
- `inj_valid` while in HOLD is ignored; there is no queueing.

Without the macro:
- The `inj_*` ports are absent.
- `inreg_eff` = `inreg`.
- No injector logic is synthesized.

## Test plan
- **Reset idle:** assert reset, release, then pulse `ie_n`=0 with no `out` activity -> `bus`=8'hFF and `line_count`=0. With `ie_n`=1 -> `bus` high-Z.
- **Shift and latch:** present `ctrl_data` bits 1,0,1,1,0,1,0,0, each stable across one `out[6]` 0->1 edge, then one `out[7]` 0->1 edge -> `inreg`=8'hB4 one cycle after `vs_rise` and `bus`=8'hB4 while `ie_n`=0.
- **Simultaneous edges:** with `sr`=8'h5A and `sdata`=1, raise `out[6]` and `out[7]` in the same cycle -> `inreg`=8'h5A, `sr`=8'hB5, `line_count`=0.
- **Line counter:** 300 hsync rising edges without vsync -> `line_count` saturates at 255. The next `vs_rise` -> `line_count`=0.
- **Injection** (macro on, `INJ_FRAMES`=2): assert `inj_valid` with 8'hEF -> `inj_ready` falls the next cycle and `bus` reads 8'hEF across 2 `vs_rise` events. `inreg_eff` returns to the controller byte the cycle after the 2nd edge and `inj_ready`=1. A second request in HOLD is ignored.
- **Reset mid-operation:** assert reset after 3 shifts and during HOLD -> all outputs take their reset values. A subsequent full 8-bit frame latches correctly.
